hpm_counter_ext: RTL and testbench
==================================

# hpm_counter_ext

Hardware performance-monitor CSR extension. It sits on the extension side of `priv_ext_if` (`ext` modport), downstream of the privileged CSR file. It owns the programmable counters `mhpmcounter3..`, their event selectors and `mcountinhibit`, and counts core event pulses independently of the main CSR file. It answers every CSR lookup combinationally and commits writes on the clock edge of an active CSR operation.

## Interface
Parameters:
- `NUM_COUNTERS`, default 4: implemented counters, indices 3..3+NUM_COUNTERS-1. Legal range 1..29.
- `EVENT_W`, default 8: number of event inputs. Legal range 1..255.

Ports:
- `CLK` in 1: core clock.
- `nRST` in 1: reset, synchronous, active-low. Sampled only on the rising edge of `CLK`.
- `csr_addr` in 12: CSR address (`priv_ext_if.csr_addr`).
- `value_in` in 32: new CSR value computed by the privileged unit.
- `csr_active` in 1: active CSR operation; write qualifier.
- `ack` out 1: `csr_addr` belongs to this block.
- `invalid_csr` out 1: illegal access to an owned CSR.
- `value_out` out 32: current value of the CSR at `csr_addr`.
- `events` in EVENT_W: per-cycle event pulses from the pipeline. Bit k is event k+1.

## Operation
Owned addresses, for i = 0..NUM_COUNTERS-1 (n = 3+i):
- `mcountinhibit` 0x320. Bits 3..n_max are writable; all other bits read 0 and ignore writes.
- `mhpmevent`n at 0x320+n: event selector, 8-bit register.
- `mhpmcounter`n at 0xB00+n: bits 31:0 of the counter.
- `mhpmcounterh`n at 0xB80+n: bits 63:32 of the counter.
- `hpmcounter`n at 0xC00+n and `hpmcounterh`n at 0xC80+n: read-only shadows of the counter halves.

Lookup behaviour:
- `ack` is 1 iff `csr_addr` is owned. Unimplemented indices are not owned.
- `value_out` is the addressed value, zero-extended. It is 0 when `ack`=0.
- `invalid_csr` is 1 iff `csr_active` && shadow address && `value_in != value_out`. In every other case it is 0.

Writes (`csr_active` && `ack` && !`invalid_csr`):
- `mhpmevent` is WARL. If `value_in` ≤ EVENT_W, store `value_in[7:0]`; otherwise store 0.
- Counter halves load `value_in`. The other half is unchanged and no carry is produced.
- An unowned address or `csr_active`=0 never changes state.

Counting, per counter i, each cycle:
- The counter increments by 1 iff !`inhibit[n]` && `sel[n]` != 0 && `events[sel[n]-1]`.
- Counters are full 64-bit and wrap 0xFFFF_FFFF_FFFF_FFFF → 0. There is no overflow flag.
- Selector 0 means the counter is idle.
- A CSR write to either half of counter i in the same cycle as an increment wins: the increment for that cycle is dropped.

Reset (`nRST`=0 at an edge):
- All counters, selectors and inhibit bits are cleared to 0.
- Reset overrides any same-cycle write or increment.
- After reset, every owned read returns 0. Outputs are combinational: `ack`=0, `value_out`=0 and `invalid_csr`=0 whenever the address is unowned.

## Timing
- Lookup latency is 0 cycles: `ack`, `value_out` and `invalid_csr` settle in the same cycle as `csr_addr`, `value_in` and `csr_active`.
- Write latency is 1 edge. A read in cycle t+1 returns the value written in cycle t.
- An event sampled in cycle t is visible in the counter in cycle t+1.
- Inhibit and selector writes take effect from the next cycle. An event in the write cycle uses the old inhibit and selector values.
- There is no back-pressure and no multi-cycle operation; every access completes in its cycle.

## Test plan
- Reset, then sweep 0x320, 0x323, 0xB03, 0xB83 and 0xC03: `ack`=1 and `value_out`=0. At 0xB07 (index 7, unimplemented with NUM_COUNTERS=4): `ack`=0 and `value_out`=0.
- Write `mhpmevent3`=2 and hold `events[1]`=1 for 10 cycles: `mhpmcounter3` reads 10. Write `mcountinhibit`=0x8 and pulse 5 more events: the counter stays 10.
- Write `mhpmcounter3`=0xFFFF_FFFF and `mhpmcounterh3`=0xFFFF_FFFF, then apply 2 events: the low half reads 1 and the high half reads 0 (wrap).
- Write `mhpmcounter4`=0x100 in the same cycle as a selected event: the next cycle reads 0x100, not 0x101.
- Apply `csr_active` at 0xC03 with `value_in`=`value_out`: `invalid_csr`=0. With `value_in`=5 and the counter at 3: `invalid_csr`=1 and the counter continues from 3. Writing `mhpmevent5`=EVENT_W+1 reads back 0.
- Assert `nRST`=0 for one edge in the same cycle as a counter write and an event: all registers read 0 afterwards.

Source files
------------

// File: rtl/hpm_counter_ext_if.sv
// CSR lookup bus between the privileged CSR file (master) and an extension block (slave/ext).
interface priv_ext_if;
  logic [11:0] csr_addr;
  logic [31:0] value_in;
  logic        csr_active;
  logic        ack;
  logic        invalid_csr;
  logic [31:0] value_out;

  modport master (
    output csr_addr, value_in, csr_active,
    input  ack, invalid_csr, value_out
  );

  modport slave (
    input  csr_addr, value_in, csr_active,
    output ack, invalid_csr, value_out
  );

  modport ext (
    input  csr_addr, value_in, csr_active,
    output ack, invalid_csr, value_out
  );
endinterface

// File: rtl/hpm_counter_ext.sv
// Programmable HPM counters (mhpmcounter3..), event selectors and mcountinhibit.
// Combinational CSR lookup; writes and event counting commit on the rising clock edge.
module hpm_counter_ext #(
  parameter int NUM_COUNTERS = 4,
  parameter int EVENT_W      = 8
) (
  input  logic               CLK,
  input  logic               nRST,
  priv_ext_if.slave          bus,
  input  logic [EVENT_W-1:0] events
);

  // Address = {group[11:5], index[4:0]}; every owned CSR family occupies one 32-entry group.
  localparam logic [6:0] GRP_EVT    = 7'h19;
  localparam logic [6:0] GRP_CNT_LO = 7'h58;
  localparam logic [6:0] GRP_CNT_HI = 7'h5C;
  localparam logic [6:0] GRP_SH_LO  = 7'h60;
  localparam logic [6:0] GRP_SH_HI  = 7'h64;

  localparam logic [63:0] INH_FULL = (64'd1 << (3 + NUM_COUNTERS)) - 64'd1;
  localparam logic [31:0] INH_MASK = INH_FULL[31:0] & 32'hFFFF_FFF8;

  logic [31:0] r_inhibit;
  logic [7:0]  r_sel [NUM_COUNTERS];
  logic [63:0] r_cnt [NUM_COUNTERS];

  logic [4:0]              w_n;
  logic [6:0]              w_grp;
  logic                    w_ack;
  logic                    w_shadow;
  logic                    w_invalid;
  logic                    w_wr;
  logic [31:0]             w_rdata;
  logic                    w_hit_inh;
  logic [NUM_COUNTERS-1:0] w_hit_sel;
  logic [NUM_COUNTERS-1:0] w_hit_lo;
  logic [NUM_COUNTERS-1:0] w_hit_hi;
  logic [NUM_COUNTERS-1:0] w_inc;
  logic [7:0]              w_sel_warl;
  logic [255:0]            w_ev_ext;

  assign w_n   = bus.csr_addr[4:0];
  assign w_grp = bus.csr_addr[11:5];

  always_comb begin
    w_hit_inh = (w_grp == GRP_EVT) && (w_n == 5'd0);
    w_ack     = w_hit_inh;
    w_shadow  = 1'b0;
    w_rdata   = w_hit_inh ? r_inhibit : 32'd0;
    w_hit_sel = '0;
    w_hit_lo  = '0;
    w_hit_hi  = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (w_n == 5'(i + 3)) begin
        case (w_grp)
          GRP_EVT: begin
            w_hit_sel[i] = 1'b1;
            w_ack        = 1'b1;
            w_rdata      = {24'd0, r_sel[i]};
          end
          GRP_CNT_LO: begin
            w_hit_lo[i] = 1'b1;
            w_ack       = 1'b1;
            w_rdata     = r_cnt[i][31:0];
          end
          GRP_CNT_HI: begin
            w_hit_hi[i] = 1'b1;
            w_ack       = 1'b1;
            w_rdata     = r_cnt[i][63:32];
          end
          GRP_SH_LO: begin
            w_shadow = 1'b1;
            w_ack    = 1'b1;
            w_rdata  = r_cnt[i][31:0];
          end
          GRP_SH_HI: begin
            w_shadow = 1'b1;
            w_ack    = 1'b1;
            w_rdata  = r_cnt[i][63:32];
          end
          default: ;
        endcase
      end
    end
  end

  // Shadows are read-only: an active access must not try to change the value.
  assign w_invalid = bus.csr_active && w_shadow && (bus.value_in != w_rdata);
  assign w_wr      = bus.csr_active && w_ack && !w_invalid;

  assign w_sel_warl = (bus.value_in <= 32'(EVENT_W)) ? bus.value_in[7:0] : 8'd0;

  // Bit 0 is tied low so selector 0 never matches and selector k picks event k.
  assign w_ev_ext = 256'({events, 1'b0});

  always_comb begin
    w_inc = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      w_inc[i] = !r_inhibit[i + 3] && w_ev_ext[r_sel[i]];
    end
  end

  assign bus.ack         = w_ack;
  assign bus.value_out   = w_rdata;
  assign bus.invalid_csr = w_invalid;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_inhibit <= 32'd0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        r_sel[i] <= 8'd0;
        r_cnt[i] <= 64'd0;
      end
    end else begin
      if (w_wr && w_hit_inh) begin
        r_inhibit <= bus.value_in & INH_MASK;
      end
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (w_wr && w_hit_sel[i]) begin
          r_sel[i] <= w_sel_warl;
        end
        // A CSR write to either half drops that cycle's increment.
        if (w_wr && w_hit_lo[i]) begin
          r_cnt[i][31:0] <= bus.value_in;
        end else if (w_wr && w_hit_hi[i]) begin
          r_cnt[i][63:32] <= bus.value_in;
        end else if (w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] + 64'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hpm_counter_ext.sv
// Self-checking bench for hpm_counter_ext: lookup/write tables plus counting corner sequences.
module tb_hpm_counter_ext;
  localparam int NC = 4;
  localparam int EW = 8;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [EW-1:0] events = '0;

  priv_ext_if bus();

  hpm_counter_ext #(.NUM_COUNTERS(NC), .EVENT_W(EW)) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .bus    (bus),
    .events (events)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        ack;
    logic [31:0] val;
    logic        inv;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    logic        ack;
    logic [31:0] val;
  } rd_vec_t;

  typedef struct {
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] rval;
  } wr_vec_t;

  exp_t    sb[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  rd_vec_t sweep   [10];
  rd_vec_t cleared [8];
  wr_vec_t wtab    [7];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [11:0] a, input logic [31:0] v, input logic act);
    bus.csr_addr   = a;
    bus.value_in   = v;
    bus.csr_active = act;
  endtask

  task automatic check_out();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: output sampled with no expectation queued");
      return;
    end
    e = sb.pop_front();
    if (bus.ack !== e.ack || bus.value_out !== e.val || bus.invalid_csr !== e.inv) begin
      n_bad++;
      $display("FAIL %s: got ack=%0b value_out=%h invalid=%0b, expected ack=%0b value_out=%h invalid=%0b",
               e.name, bus.ack, bus.value_out, bus.invalid_csr, e.ack, e.val, e.inv);
    end
  endtask

  // Drive one lookup, compare mid-cycle, then let the edge pass with the access held.
  task automatic look(input string nm, input logic [11:0] a, input logic [31:0] v, input logic act,
                      input logic eack, input logic [31:0] eval, input logic einv);
    exp_t e;
    drive(a, v, act);
    e.name = nm;
    e.ack  = eack;
    e.val  = eval;
    e.inv  = einv;
    sb.push_back(e);
    #2;
    check_out();
    step();
    bus.csr_active = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    drive(a, v, 1'b1);
    step();
    bus.csr_active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sweep = '{
      '{12'h320, 1'b1, 32'd0}, '{12'h323, 1'b1, 32'd0}, '{12'hB03, 1'b1, 32'd0},
      '{12'hB83, 1'b1, 32'd0}, '{12'hC03, 1'b1, 32'd0}, '{12'hC86, 1'b1, 32'd0},
      '{12'hB07, 1'b0, 32'd0}, '{12'h321, 1'b0, 32'd0}, '{12'h340, 1'b0, 32'd0},
      '{12'hB02, 1'b0, 32'd0}
    };
    wtab = '{
      '{12'h323, 32'd2,          12'h323, 32'd2},
      '{12'h324, 32'd8,          12'h324, 32'd8},
      '{12'h325, 32'd9,          12'h325, 32'd0},
      '{12'h326, 32'h102,        12'h326, 32'd0},
      '{12'hB04, 32'h1234_5678,  12'hC04, 32'h1234_5678},
      '{12'hB84, 32'h0000_CAFE,  12'hC84, 32'h0000_CAFE},
      '{12'h320, 32'hFFFF_FFFF,  12'h320, 32'h0000_0078}
    };
    cleared = '{
      '{12'h320, 1'b1, 32'd0}, '{12'h323, 1'b1, 32'd0}, '{12'h324, 1'b1, 32'd0},
      '{12'hB03, 1'b1, 32'd0}, '{12'hB83, 1'b1, 32'd0}, '{12'hB04, 1'b1, 32'd0},
      '{12'hB84, 1'b1, 32'd0}, '{12'hC03, 1'b1, 32'd0}
    };

    drive(12'h000, 32'd0, 1'b0);
    repeat (2) step();
    nRST = 1'b1;

    foreach (sweep[k])
      look($sformatf("reset_sweep_%h", sweep[k].addr), sweep[k].addr, 32'd0, 1'b0,
           sweep[k].ack, sweep[k].val, 1'b0);

    foreach (wtab[k]) begin
      wr(wtab[k].waddr, wtab[k].wdata);
      look($sformatf("write_%h_read_%h", wtab[k].waddr, wtab[k].raddr), wtab[k].raddr, 32'd0, 1'b0,
           1'b1, wtab[k].rval, 1'b0);
    end
    wr(12'h320, 32'd0);

    // Ten cycles of event 2 on counter 3.
    events = 8'h02;
    repeat (10) step();
    events = '0;
    look("count_10", 12'hB03, 32'd0, 1'b0, 1'b1, 32'd10, 1'b0);

    wr(12'h320, 32'h8);
    repeat (5) begin
      events = 8'h02;
      step();
      events = '0;
      step();
    end
    look("inhibited_stays_10", 12'hB03, 32'd0, 1'b0, 1'b1, 32'd10, 1'b0);

    events = 8'h02;
    wr(12'h320, 32'd0);
    events = '0;
    look("uninhibit_cycle_uses_old", 12'hB03, 32'd0, 1'b0, 1'b1, 32'd10, 1'b0);
    events = 8'h02;
    step();
    events = '0;
    look("count_after_uninhibit", 12'hB03, 32'd0, 1'b0, 1'b1, 32'd11, 1'b0);

    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    events = 8'h02;
    repeat (2) step();
    events = '0;
    look("wrap_lo", 12'hB03, 32'd0, 1'b0, 1'b1, 32'd1, 1'b0);
    look("wrap_hi", 12'hB83, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0);

    events = 8'h80;
    wr(12'hB04, 32'h100);
    events = '0;
    look("write_beats_inc", 12'hB04, 32'd0, 1'b0, 1'b1, 32'h100, 1'b0);
    look("other_half_kept", 12'hB84, 32'd0, 1'b0, 1'b1, 32'h0000_CAFE, 1'b0);
    events = 8'h80;
    step();
    events = '0;
    look("sel8_counts", 12'hB04, 32'd0, 1'b0, 1'b1, 32'h101, 1'b0);

    wr(12'hB03, 32'd3);
    look("shadow_same_value", 12'hC03, 32'd3, 1'b1, 1'b1, 32'd3, 1'b0);
    look("shadow_diff_value", 12'hC03, 32'd5, 1'b1, 1'b1, 32'd3, 1'b1);
    look("shadow_no_effect", 12'hB03, 32'd0, 1'b0, 1'b1, 32'd3, 1'b0);
    look("shadow_hi_same", 12'hC83, 32'd0, 1'b1, 1'b1, 32'd0, 1'b0);
    look("unowned_active", 12'h321, 32'd7, 1'b1, 1'b0, 32'd0, 1'b0);
    look("unimpl_active", 12'hB07, 32'd1, 1'b1, 1'b0, 32'd0, 1'b0);
    look("counter3_unchanged", 12'hB03, 32'd0, 1'b0, 1'b1, 32'd3, 1'b0);

    // Reset coincident with a counter write and a selected event.
    drive(12'hB03, 32'h55, 1'b1);
    events = 8'h02;
    nRST   = 1'b0;
    step();
    nRST   = 1'b1;
    bus.csr_active = 1'b0;
    events = '0;
    foreach (cleared[k])
      look($sformatf("post_reset_%h", cleared[k].addr), cleared[k].addr, 32'd0, 1'b0,
           cleared[k].ack, cleared[k].val, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
